// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Widest operand supported; ALL_ONES is sliced down to WIDTH by the user.
    localparam int unsigned MAX_WIDTH = 64;
    localparam logic [MAX_WIDTH-1:0] ALL_ONES = '1;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_sign_fixup.sv
// Combinational conditional two's-complement negate (abs at capture, sign fix at the end).
module muldiv_sign_fixup #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    // Negate when requested, otherwise pass through.
    always_comb begin
        result = negate ? (~value + WIDTH'(1)) : value;
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Optional macro MULDIV_ZERO_BYPASS_EN: zero-operand operations skip the RUN phase.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] hi_wdata,
    input  logic [WIDTH-1:0] lo_wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [1:0]           op_q;
    // Multiply: {partial product, multiplier}. Divide: {remainder, quotient/dividend}.
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opb_q;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     raw_rs_q;   // dividend as given, for the divide-by-zero HI value
    logic                 neg_res_q;  // product / quotient sign
    logic                 neg_rem_q;  // remainder sign (dividend sign)
    logic                 div0_q;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 done_q;

    logic                 neg_rs, neg_rt;
    logic [WIDTH-1:0]     abs_rs, abs_rt;
    logic                 bypass;
    logic [WIDTH-1:0]     mul_addend;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift, div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fixed;
    logic [WIDTH-1:0]     quo_fixed, rem_fixed;

    assign neg_rs = op_is_signed(op) & rs_val[WIDTH-1];
    assign neg_rt = op_is_signed(op) & rt_val[WIDTH-1];

    muldiv_sign_fixup #(.WIDTH(WIDTH)) u_abs_rs (
        .value  (rs_val),
        .negate (neg_rs),
        .result (abs_rs)
    );

    muldiv_sign_fixup #(.WIDTH(WIDTH)) u_abs_rt (
        .value  (rt_val),
        .negate (neg_rt),
        .result (abs_rt)
    );

    muldiv_sign_fixup #(.WIDTH(2*WIDTH)) u_fix_prod (
        .value  (acc_q),
        .negate (neg_res_q),
        .result (prod_fixed)
    );

    muldiv_sign_fixup #(.WIDTH(WIDTH)) u_fix_quo (
        .value  (acc_q[WIDTH-1:0]),
        .negate (neg_res_q),
        .result (quo_fixed)
    );

    muldiv_sign_fixup #(.WIDTH(WIDTH)) u_fix_rem (
        .value  (acc_q[2*WIDTH-1:WIDTH]),
        .negate (neg_rem_q),
        .result (rem_fixed)
    );

`ifdef MULDIV_ZERO_BYPASS_EN
    assign bypass = op_is_div(op) ? (rt_val == '0) : ((rs_val == '0) || (rt_val == '0));
`else
    assign bypass = 1'b0;
`endif

    // One radix-2 step for each of multiply (shift-add) and divide (restoring).
    always_comb begin
        mul_addend = acc_q[0] ? opb_q : '0;
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        mul_next   = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff   = div_shift - {1'b0, opb_q};
        div_ge     = (div_shift >= {1'b0, opb_q});
        if (div_ge) begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = bypass ? FIX : RUN;
            RUN:  if (cnt_q == '0) state_d = FIX;
            FIX:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, iteration datapath, HI/LO writes and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            op_q      <= OP_MULT;
            acc_q     <= '0;
            opb_q     <= '0;
            raw_rs_q  <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        cnt_q     <= CNT_W'(WIDTH - 1);
                        raw_rs_q  <= rs_val;
                        neg_res_q <= neg_rs ^ neg_rt;
                        neg_rem_q <= neg_rs;
                        div0_q    <= op_is_div(op) && (rt_val == '0);
                        if (op_is_div(op)) begin
                            acc_q <= {{WIDTH{1'b0}}, abs_rs};
                            opb_q <= abs_rt;
                        end else begin
                            // A bypassed multiply has a zero operand, so its product is zero.
                            acc_q <= bypass ? '0 : {{WIDTH{1'b0}}, abs_rt};
                            opb_q <= abs_rs;
                        end
                    end else if (!done_q) begin
                        if (mthi) hi_q <= hi_wdata;
                        if (mtlo) lo_q <= lo_wdata;
                    end
                end
                RUN: begin
                    acc_q <= op_is_div(op_q) ? div_next : mul_next;
                    if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
                end
                FIX: begin
                    done_q <= 1'b1;
                    if (!op_is_div(op_q)) begin
                        {hi_q, lo_q} <= prod_fixed;
                    end else if (div0_q) begin
                        lo_q <= ALL_ONES[WIDTH-1:0];
                        hi_q <= raw_rs_q;
                    end else begin
                        lo_q <= quo_fixed;
                        hi_q <= rem_fixed;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed table-driven bench for hilo_muldiv_unit plus multi-cycle corner sequences.
module tb_hilo_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] hi_wdata = '0;
    logic [31:0] lo_wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .hi_wdata (hi_wdata),
        .lo_wdata (lo_wdata),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        string       nm;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_ZERO_BYPASS_EN
        if (o[1] ? (b == 0) : (a == 0 || b == 0)) return 2;
`endif
        return 34;
    endfunction

    // Called anywhere within cycle 0; returns just after the sample point of the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string nm,
                          input logic with_mtlo, input int poke_at);
        int lat, busy_n, done_at;
        lat = latency(o, a, b);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        mtlo = with_mtlo; lo_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        start = 1'b0; mtlo = 1'b0;
        rs_val = ~a; rt_val = b ^ 32'h5A5A5A5A;
        busy_n = 0; done_at = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (start) start = 1'b0;
            if (done) begin
                done_at = k;
                chk({nm, " busy_in_done_cycle"}, busy, 0);
                break;
            end
            if (busy) busy_n++;
            if (k == poke_at) begin
                start = 1'b1; op = OP_DIVU; rs_val = 100; rt_val = 7;
            end
        end
        chk({nm, " done_cycle"}, done_at, lat);
        chk({nm, " busy_cycles"}, busy_n, lat - 1);
        chk({nm, " hi"}, hi, eh);
        chk({nm, " lo"}, lo, el);
    endtask

    initial begin
        int cnt;
        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_m3x7"};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7d2"};
        vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, "divu_7d2"};
        vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"};
        vecs[5]  = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, "divu_by0"};
        vecs[6]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7dm2"};
        vecs[7]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mult_m1xm1"};
        vecs[8]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, "multu_shift"};
        vecs[9]  = '{OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, "div_m5by0"};
        vecs[10] = '{OP_MULT,  32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, "mult_zero"};
        vecs[11] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min_sq"};
        vecs[12] = '{OP_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, "multu_carry"};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        @(posedge clk); #1;

        // Back-to-back: each new start is issued in the previous done cycle.
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, vecs[i].nm, 1'b0, 0);
        end

        // mthi in the done cycle is dropped (hi still 1 from multu_carry).
        mthi = 1'b1; hi_wdata = 32'h00005555;
        @(posedge clk); #1 mthi = 1'b0;
        @(negedge clk);
        chk("mthi_in_done_cycle hi", hi, 32'h00000001);

        // mthi in IDLE lands on the next edge.
        mthi = 1'b1; hi_wdata = 32'h00001234;
        @(posedge clk); #1 mthi = 1'b0;
        @(negedge clk);
        chk("mthi_idle hi", hi, 32'h00001234);
        chk("mthi_idle lo", lo, 32'h00000000);

        mtlo = 1'b1; lo_wdata = 32'h0000CAFE;
        @(posedge clk); #1 mtlo = 1'b0;
        @(negedge clk);
        chk("mtlo_idle lo", lo, 32'h0000CAFE);

        // mtlo together with start: the product wins.
        run_op(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, "mtlo_with_start", 1'b1, 0);

        // mthi while busy is ignored.
        @(posedge clk); #1;
        op = OP_MULTU; rs_val = 32'd6; rt_val = 32'd7; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        mthi = 1'b1; hi_wdata = 32'h00009999;
        @(negedge clk);
        @(negedge clk);
        chk("mthi_busy busy", busy, 1);
        chk("mthi_busy hi_held", hi, 32'h00000000);
        mthi = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("mthi_busy done", done, 1);
        chk("mthi_busy lo", lo, 32'd42);

        // A start issued while busy is neither honoured nor queued.
        run_op(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, "start_while_busy", 1'b0, 5);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        chk("start_while_busy not_queued", cnt, 0);

        // Mid-operation reset aborts with no done pulse; lo is 12 before the reset.
        op = OP_MULTU; rs_val = 32'd3; rt_val = 32'd4; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1; op = OP_DIVU; rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("reset_abort busy", busy, 0);
        chk("reset_abort done", done, 0);
        chk("reset_abort hi", hi, 0);
        chk("reset_abort lo", lo, 0);
        @(posedge clk); #1 reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        chk("reset_abort no_activity", cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
